// File: rtl/gin_leak_sequencer_if.sv
// Bus between the gin leak sequencer and its gin memory, leak unit and controller.
// Master side is the sequencer; slave side is the surrounding datapath.
interface gin_leak_sequencer_if #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int ADDR_WIDTH      = 8
);
    logic                     Start;
    logic [ADDR_WIDTH:0]      NeuronCount;
    logic [DELTAT_WIDTH-1:0]  DeltaT;
    logic [INTEGER_WIDTH-1:0] Taugin;

    logic                     RdEn;
    logic [ADDR_WIDTH-1:0]    RdAddr;
    logic [DATA_WIDTH-1:0]    RdData;

    logic [DATA_WIDTH-1:0]    LeakGin;
    logic [DELTAT_WIDTH-1:0]  LeakDeltaT;
    logic [INTEGER_WIDTH-1:0] LeakTaugin;
    logic [DATA_WIDTH-1:0]    LeakGinOut;

    logic                     WrEn;
    logic [ADDR_WIDTH-1:0]    WrAddr;
    logic [DATA_WIDTH-1:0]    WrData;

    logic                     Busy;
    logic                     Done;
    logic                     Error;

    modport master (
        input  Start, NeuronCount, DeltaT, Taugin, RdData, LeakGinOut,
        output RdEn, RdAddr, LeakGin, LeakDeltaT, LeakTaugin,
               WrEn, WrAddr, WrData, Busy, Done, Error
    );

    modport slave (
        output Start, NeuronCount, DeltaT, Taugin, RdData, LeakGinOut,
        input  RdEn, RdAddr, LeakGin, LeakDeltaT, LeakTaugin,
               WrEn, WrAddr, WrData, Busy, Done, Error
    );
endinterface

// File: rtl/gin_leak_sequencer.sv
// Sweeps the gin leak over NeuronCount neurons: read, capture, write back, 3 cycles each.
// Optional GIN_LEAK_SIGN_CLAMP_EN zeroes write-back when the leak overshoots through zero.
module gin_leak_sequencer #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    gin_leak_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH:0]      count_q, count_d;
    logic [DELTAT_WIDTH-1:0]  dt_q, dt_d;
    logic [INTEGER_WIDTH-1:0] tau_q, tau_d;
    logic [DATA_WIDTH-1:0]    gin_q, gin_d;

    // Extra bit so a full 2^ADDR_WIDTH sweep terminates instead of wrapping.
    logic [ADDR_WIDTH:0]      idx_next;
    logic [DATA_WIDTH-1:0]    wr_data;

    assign idx_next = {1'b0, idx_q} + (ADDR_WIDTH+1)'(1);

`ifdef GIN_LEAK_SIGN_CLAMP_EN
    always_comb begin
        wr_data = bus.LeakGinOut;
        if ((bus.LeakGinOut != '0) && (bus.LeakGinOut[DATA_WIDTH-1] != gin_q[DATA_WIDTH-1]))
            wr_data = '0;
    end
`else
    assign wr_data = bus.LeakGinOut;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            dt_q    <= '0;
            tau_q   <= '0;
            gin_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            dt_q    <= dt_d;
            tau_q   <= tau_d;
            gin_q   <= gin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        dt_d      = dt_q;
        tau_d     = tau_q;
        gin_d     = gin_q;
        bus.RdEn  = 1'b0;
        bus.WrEn  = 1'b0;
        bus.Done  = 1'b0;
        bus.Error = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    count_d = bus.NeuronCount;
                    dt_d    = bus.DeltaT;
                    tau_d   = bus.Taugin;
                    idx_d   = '0;
                    state_d = ((bus.NeuronCount != '0) && (bus.Taugin != '0)) ? READ : DONE;
                end
            end
            READ: begin
                bus.RdEn = 1'b1;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                gin_d   = bus.RdData;
                state_d = WRITE;
            end
            WRITE: begin
                bus.WrEn = 1'b1;
                if (idx_next < count_q) begin
                    idx_d   = idx_next[ADDR_WIDTH-1:0];
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.Done  = 1'b1;
                bus.Error = (tau_q == '0);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy       = (state_q != IDLE);
    assign bus.RdAddr     = idx_q;
    assign bus.WrAddr     = idx_q;
    assign bus.WrData     = wr_data;
    assign bus.LeakGin    = gin_q;
    assign bus.LeakDeltaT = dt_q;
    assign bus.LeakTaugin = tau_q;
endmodule

// File: tb/tb_gin_leak_sequencer.sv
// Directed and randomized sweeps against a cycle-timing and memory-content reference model.
// Honours GIN_LEAK_SIGN_CLAMP_EN the same way as the design build.
module tb_gin_leak_sequencer;
    localparam int NMAX = 256;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    gin_leak_sequencer_if bus ();
    gin_leak_sequencer dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    logic [63:0] mem  [NMAX];
    logic [63:0] orig [NMAX];
    logic [63:0] rd_q = '0;
    logic        load = 1'b0;
    int checks = 0;
    int errors = 0;

    // Leak unit stand-in: gin * (1 - dt/tau) in plain integer arithmetic.
    function automatic logic [63:0] leak_f(logic [63:0] g, logic [3:0] dt, logic [31:0] tau);
        longint gs = longint'(g);
        longint t  = longint'({32'b0, tau});
        if (t == 0) return g;
        return 64'(gs - (gs * longint'({60'b0, dt})) / t);
    endfunction

    function automatic logic [63:0] exp_wr(logic [63:0] g, logic [3:0] dt, logic [31:0] tau);
        logic [63:0] r = leak_f(g, dt, tau);
`ifdef GIN_LEAK_SIGN_CLAMP_EN
        if (r != 0 && r[63] != g[63]) r = '0;
`endif
        return r;
    endfunction

    assign bus.LeakGinOut = leak_f(bus.LeakGin, bus.LeakDeltaT, bus.LeakTaugin);
    assign bus.RdData     = rd_q;

    always @(posedge Clock) begin
        if (load) mem <= orig;
        else if (bus.WrEn) mem[bus.WrAddr] <= bus.WrData;
        if (bus.RdEn) rd_q <= mem[bus.RdAddr];
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.NeuronCount = 9'($urandom_range(0, 256));
        bus.DeltaT      = 4'($urandom);
        bus.Taugin      = $urandom;
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_rden"}, 64'(bus.RdEn), 0);
        chk({tag, "_wren"}, 64'(bus.WrEn), 0);
        chk({tag, "_busy"}, 64'(bus.Busy), 0);
        chk({tag, "_done"}, 64'(bus.Done), 0);
        chk({tag, "_err"},  64'(bus.Error), 0);
        chk({tag, "_ltau"}, 64'(bus.LeakTaugin), 0);
        chk({tag, "_ldt"},  64'(bus.LeakDeltaT), 0);
        chk({tag, "_lgin"}, bus.LeakGin, 0);
    endtask

    // One sweep: n neurons; restart pulses Start in cycle 5; rst_cyc>0 resets mid-cycle rst_cyc.
    task automatic sweep(string tag, int n, int dt, int tau, bit restart, int rst_cyc,
                         bit use_g0, logic [63:0] g0);
        bit en;
        int dc, written;
        for (int i = 0; i < NMAX; i++) begin
            logic [63:0] r = {$urandom, $urandom};
            orig[i] = 64'($signed(r) >>> 24);
        end
        if (use_g0) orig[0] = g0;
        @(negedge Clock) load = 1'b1;
        @(negedge Clock) load = 1'b0;
        bus.Start = 1'b1;
        bus.NeuronCount = 9'(n);
        bus.DeltaT = 4'(dt);
        bus.Taugin = 32'(tau);
        @(posedge Clock);
        #1 bus.Start = 1'b0;
        scramble_inputs();
        en = (n != 0) && (tau != 0);
        dc = en ? 3 * n + 1 : 1;
        written = en ? n : 0;
        for (int k = 1; k <= dc + 1; k++) begin
            bit e_rd, e_wr;
            int idx;
            @(negedge Clock);
            e_rd = en && k <= 3 * n && (k % 3) == 1;
            e_wr = en && k <= 3 * n && (k % 3) == 0;
            idx  = (k - 1) / 3;
            chk({tag, "_rden"}, 64'(bus.RdEn), 64'(e_rd));
            chk({tag, "_wren"}, 64'(bus.WrEn), 64'(e_wr));
            if (e_rd) chk({tag, "_rdaddr"}, 64'(bus.RdAddr), 64'(idx));
            if (e_wr) begin
                chk({tag, "_wraddr"}, 64'(bus.WrAddr), 64'(idx));
                chk({tag, "_wrdata"}, bus.WrData, exp_wr(orig[idx], 4'(dt), 32'(tau)));
            end
            chk({tag, "_done"}, 64'(bus.Done), 64'(k == dc));
            chk({tag, "_err"},  64'(bus.Error), 64'(k == dc && tau == 0));
            chk({tag, "_busy"}, 64'(bus.Busy), 64'(k <= dc));
            if (k <= dc) begin
                chk({tag, "_ldt"},  64'(bus.LeakDeltaT), 64'(dt));
                chk({tag, "_ltau"}, 64'(bus.LeakTaugin), 64'(tau));
            end
            if (restart && k == 5) begin
                bus.Start = 1'b1;
                scramble_inputs();
            end
            if (restart && k == 6) bus.Start = 1'b0;
            if (rst_cyc == k) begin
                Reset = 1'b0;
                #1 check_quiet({tag, "_rst"});
                repeat (3) begin
                    @(negedge Clock);
                    chk({tag, "_rst_rden"}, 64'(bus.RdEn), 0);
                    chk({tag, "_rst_wren"}, 64'(bus.WrEn), 0);
                end
                Reset = 1'b1;
                written = (rst_cyc - 1) / 3;
                break;
            end
        end
        @(negedge Clock);
        for (int i = 0; i < NMAX; i++)
            chk({tag, "_mem"}, mem[i],
                (i < written) ? exp_wr(orig[i], 4'(dt), 32'(tau)) : orig[i]);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.NeuronCount = '0;
        bus.DeltaT = '0;
        bus.Taugin = '0;
        #12 check_quiet("reset");
        @(negedge Clock) Reset = 1'b1;
        @(negedge Clock) check_quiet("idle");

        sweep("basic4",   4, 1, 10, 1'b0, 0, 1'b0, '0);
        sweep("zero_n",   0, 3, 7,  1'b0, 0, 1'b0, '0);
        sweep("tau0",     5, 2, 0,  1'b0, 0, 1'b0, '0);
        sweep("tau0_n0",  0, 2, 0,  1'b0, 0, 1'b0, '0);
        sweep("restart",  4, 2, 9,  1'b1, 0, 1'b0, '0);
        sweep("full",     256, 1, 3, 1'b0, 0, 1'b0, '0);
        sweep("rst_cap2", 4, 1, 10, 1'b0, 8, 1'b0, '0);
        sweep("after_rst", 3, 5, 4, 1'b0, 0, 1'b0, '0);
        sweep("overshoot", 1, 3, 2, 1'b0, 0, 1'b1, 64'h0000_0001_0000_0000);
`ifdef GIN_LEAK_SIGN_CLAMP_EN
        chk("overshoot_const", mem[0], 64'h0);
`else
        chk("overshoot_const", mem[0], 64'hFFFF_FFFF_8000_0000);
`endif
        for (int s = 0; s < 12; s++) begin
            int n   = $urandom_range(0, 24);
            int tau = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            int rc  = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, 3 * n) : 0;
            sweep("rand", n, $urandom_range(0, 15), tau, 1'(s % 2), rc, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
